// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared LC-3b fetch encodings and helpers
package fetch_stage_pkg;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } fetch_state_e;

  localparam logic [1:0]  PCMUX_NPC  = 2'b00;
  localparam logic [1:0]  PCMUX_TGT  = 2'b01;
  localparam logic [1:0]  PCMUX_TRAP = 2'b10;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h3000;

  // Word-sized PC step; wraps modulo 2^16 and leaves bit 0 untouched.
  function automatic logic [15:0] pc_inc(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - one-entry ir/npc skid buffer for a stalled decode stage
module fetch_hold_buf (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_unload,
  input  logic        i_flush,
  input  logic [15:0] i_ir,
  input  logic [15:0] i_npc,
  output logic        o_valid,
  output logic [15:0] o_ir,
  output logic [15:0] o_npc
);

  logic        r_valid;
  logic [15:0] r_ir;
  logic [15:0] r_npc;

  // Flush beats load so a redirect can never leave a stale word behind.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_ir    <= 16'h0000;
      r_npc   <= 16'h0000;
    end else begin
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (i_load) begin
        r_valid <= 1'b1;
      end else if (i_unload) begin
        r_valid <= 1'b0;
      end
      if (i_load && !i_flush) begin
        r_ir  <= i_ir;
        r_npc <= i_npc;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_ir    = r_ir;
  assign o_npc   = r_npc;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - LC-3b fetch stage: PC, imem request, DE latch
// Owns the PC, buffers one word while decode stalls, and applies MEM-resolved redirects.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dep_stall,
  input  logic        mem_stall,
  input  logic        v_de_br_stall,
  input  logic        v_agex_br_stall,
  input  logic        v_mem_br_stall,
  input  logic [1:0]  mem_pcmux,
  input  logic [15:0] target_pc,
  input  logic [15:0] trap_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic [15:0] de_npc,
  output logic [15:0] de_ir,
  output logic        de_v
);

  fetch_state_e r_state;
  logic [15:0]  r_pc;
  logic [15:0]  r_de_npc;
  logic [15:0]  r_de_ir;
  logic         r_de_v;

  logic         w_ld_de;
  logic         w_br_stall;
  logic         w_redirect;
  logic [15:0]  w_redirect_pc;
  logic [15:0]  w_pc_inc;
  logic         w_fetch_done;
  logic         w_hold_load;
  logic         w_hold_unload;
  logic         w_hold_v;
  logic [15:0]  w_hold_ir;
  logic [15:0]  w_hold_npc;

  assign w_ld_de    = ~dep_stall & ~mem_stall;
  assign w_br_stall = v_de_br_stall | v_agex_br_stall | v_mem_br_stall;
  assign w_pc_inc   = pc_inc(r_pc);

  always_comb begin
    w_redirect    = 1'b0;
    w_redirect_pc = r_pc;
    case (mem_pcmux)
      PCMUX_NPC:  w_redirect = 1'b0;
      PCMUX_TGT: begin
        w_redirect    = 1'b1;
        w_redirect_pc = target_pc;
      end
      PCMUX_TRAP: begin
        w_redirect    = 1'b1;
        w_redirect_pc = trap_pc;
      end
      default:    w_redirect = 1'b0;
    endcase
  end

  // Gated by reset so an in-flight request is dropped the instant reset rises.
  assign imem_req      = ~reset & (r_state == S_FETCH) & ~w_br_stall & ~w_redirect;
  assign imem_addr     = r_pc;
  assign w_fetch_done  = imem_req & imem_rdy;
  assign w_hold_load   = w_fetch_done & ~w_ld_de;
  assign w_hold_unload = (r_state == S_HOLD) & w_ld_de & ~w_redirect;

  fetch_hold_buf u_hold (
    .i_clk    (clk),
    .i_rst    (reset),
    .i_load   (w_hold_load),
    .i_unload (w_hold_unload),
    .i_flush  (w_redirect),
    .i_ir     (imem_data),
    .i_npc    (w_pc_inc),
    .o_valid  (w_hold_v),
    .o_ir     (w_hold_ir),
    .o_npc    (w_hold_npc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_de_npc <= 16'h0000;
      r_de_ir  <= 16'h0000;
      r_de_v   <= 1'b0;
    end else if (w_redirect) begin
      r_pc    <= w_redirect_pc;
      r_state <= S_FETCH;
      if (w_ld_de) r_de_v <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_fetch_done) begin
            r_pc <= w_pc_inc;
            if (w_ld_de) begin
              r_de_ir  <= imem_data;
              r_de_npc <= w_pc_inc;
              r_de_v   <= 1'b1;
            end else begin
              r_state <= S_HOLD;
            end
          end else if (w_ld_de) begin
            r_de_v <= 1'b0;
          end
        end
        S_HOLD: begin
          if (w_ld_de && w_hold_v) begin
            r_de_ir  <= w_hold_ir;
            r_de_npc <= w_hold_npc;
            r_de_v   <= 1'b1;
            r_state  <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign de_npc = r_de_npc;
  assign de_ir  = r_de_ir;
  assign de_v   = r_de_v;

endmodule
